serial_add_ctrl: RTL and testbench

SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

---
 rtl/serial_add_ctrl_pkg.sv | 18 +
 rtl/full_adder.sv | 13 +
 rtl/serial_add_ctrl.sv | 123 ++++++++++++
 tb/tb_serial_add_ctrl.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/serial_add_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller: default width,
// FSM state encoding and counter sizing helper.
package serial_add_ctrl_pkg;

  localparam int DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // Bit counter must reach WIDTH-1 without wrapping; keep at least one bit.
  function automatic int cnt_bits(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full adder; the single arithmetic element of the serial adder.
module full_adder (
  output logic S,
  output logic Cout,
  input  logic A,
  input  logic B,
  input  logic Cin
);

  assign S    = A ^ B ^ Cin;
  assign Cout = (A & B) | (Cin & (A ^ B));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: operands are shifted LSB first through one full adder,
// and the WIDTH-bit result is published on sum/cout only when complete.
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int              CNT_W    = cnt_bits(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  // Holds the lower WIDTH-1 result bits; the top bit comes straight from the adder.
  logic [WIDTH-2:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;

  logic             fa_s;
  logic             fa_cout;
  logic [WIDTH-1:0] res_ext_s;

  full_adder u_fa (
    .S    (fa_s),
    .Cout (fa_cout),
    .A    (a_sh_q[0]),
    .B    (b_sh_q[0]),
    .Cin  (carry_q)
  );

  assign res_ext_s = {fa_s, res_q};

  // Next-state, datapath shifting and result capture.
  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    res_d   = res_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        a_sh_d  = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d  = {1'b0, b_sh_q[WIDTH-1:1]};
        res_d   = res_ext_s[WIDTH-1:1];
        carry_d = fa_cout;
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          sum_d   = res_ext_s;
          cout_d  = fa_cout;
          state_d = ST_DONE;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign busy = (state_q == ST_RUN);
  assign done = (state_q == ST_DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Randomised and directed checks of serial_add_ctrl at WIDTH=8 and WIDTH=4
// against a plain-arithmetic reference of a+b+cin and the cycle timing.
module tb_serial_add_ctrl;
  import serial_add_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       start8, cin8, busy8, done8, cout8;
  logic [7:0] a8, b8, sum8;
  logic       start4, cin4, busy4, done4, cout4;
  logic [3:0] a4, b4, sum4;
  int         n_chk = 0;
  int         n_pass = 0;

  always #5 clk = ~clk;

  serial_add_ctrl #(.WIDTH(DEF_WIDTH)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_add_ctrl #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .cin(cin4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [8:0] ref_add8(input logic [7:0] x, input logic [7:0] y, input logic c);
    return {1'b0, x} + {1'b0, y} + {8'd0, c};
  endfunction

  // One 8-bit addition; optionally scrambles inputs and pulses start while busy.
  task automatic op8(input logic [7:0] x, input logic [7:0] y, input logic c, input bit scramble);
    logic [8:0] prev;
    int lat, ndone, bad_busy, bad_hold;
    prev = {cout8, sum8};
    lat = -1; ndone = 0; bad_busy = 0; bad_hold = 0;
    a8 = x; b8 = y; cin8 = c; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    for (int k = 0; k < 14; k++) begin
      if (done8 === 1'b1) begin
        ndone++;
        if (lat < 0) lat = k;
      end
      if (busy8 !== (k < 8)) bad_busy++;
      if (lat < 0 && {cout8, sum8} !== prev) bad_hold++;
      if (scramble) begin
        a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
        start8 = (busy8 || done8) ? 1'($urandom) : 1'b0;
      end
      tick();
    end
    start8 = 1'b0;
    check_val("lat8", 32'(lat), 32'd8);
    check_val("ndone8", 32'(ndone), 32'd1);
    check_val("busy8", 32'(bad_busy), 32'd0);
    check_val("hold8", 32'(bad_hold), 32'd0);
    check_val("sum8", 32'({cout8, sum8}), 32'(ref_add8(x, y, c)));
  endtask

  initial begin
    int ndone, lat, first, last, bad_gap, busy_low, bad_low, bad_sum;
    logic       prev_done;
    logic [4:0] exp4;
    rst = 1'b1;
    start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
    start4 = 1'b1; a4 = 4'hF;  b4 = 4'hF;  cin4 = 1'b1;
    tick(); tick();
    check_val("rst_busy", 32'({busy8, busy4}), 32'd0);
    check_val("rst_done", 32'({done8, done4}), 32'd0);
    check_val("rst_sum8", 32'({cout8, sum8}), 32'd0);
    check_val("rst_sum4", 32'({cout4, sum4}), 32'd0);
    rst = 1'b0; start8 = 1'b0; start4 = 1'b0;

    op8(8'h00, 8'h00, 1'b0, 1'b0);
    op8(8'hFF, 8'h01, 1'b0, 1'b0);
    op8(8'hA5, 8'h5A, 1'b1, 1'b0);
    op8(8'h0F, 8'h01, 1'b0, 1'b1);
    for (int i = 0; i < 60; i++) op8(8'($urandom), 8'($urandom), 1'($urandom), bit'($urandom));

    // Abort in the third RUN cycle; reset wins over a simultaneous start.
    op8(8'h12, 8'h34, 1'b0, 1'b0);
    a8 = 8'h3C; b8 = 8'h11; cin8 = 1'b0; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    tick(); tick();
    rst = 1'b1; start8 = 1'b1;
    tick();
    check_val("abort_busy", 32'(busy8), 32'd0);
    check_val("abort_done", 32'(done8), 32'd0);
    check_val("abort_sum", 32'({cout8, sum8}), 32'd0);
    rst = 1'b0; start8 = 1'b0;
    ndone = 0; bad_sum = 0;
    for (int k = 0; k < 14; k++) begin
      if (done8 === 1'b1) ndone++;
      if ({cout8, sum8} !== 9'd0) bad_sum++;
      tick();
    end
    check_val("abort_nodone", 32'(ndone), 32'd0);
    check_val("abort_hold", 32'(bad_sum), 32'd0);
    op8(8'hC3, 8'h7E, 1'b1, 1'b0);

    // Start held high: back-to-back operations every WIDTH+2 cycles.
    a8 = 8'h9C; b8 = 8'h77; cin8 = 1'b1; start8 = 1'b1;
    tick();
    ndone = 0; first = -1; last = -1; bad_gap = 0; busy_low = 0; bad_low = 0; bad_sum = 0;
    prev_done = 1'b0;
    for (int k = 0; k < 50; k++) begin
      if (done8 === 1'b1) begin
        ndone++;
        if (first < 0) first = k;
        if (last >= 0 && k - last != 10) bad_gap++;
        last = k;
        if ({cout8, sum8} !== ref_add8(8'h9C, 8'h77, 1'b1)) bad_sum++;
      end
      if (busy8 !== 1'b1) begin
        busy_low++;
        if (!(done8 === 1'b1 || prev_done)) bad_low++;
      end
      prev_done = done8;
      tick();
    end
    start8 = 1'b0;
    check_val("cont_first", 32'(first), 32'd8);
    check_val("cont_ndone", 32'(ndone), 32'd5);
    check_val("cont_gap", 32'(bad_gap), 32'd0);
    check_val("cont_busylow", 32'(busy_low), 32'd10);
    check_val("cont_lowpos", 32'(bad_low), 32'd0);
    check_val("cont_sum", 32'(bad_sum), 32'd0);
    for (int k = 0; k < 12; k++) tick();

    // Exhaustive 4-bit operand sweep.
    for (int i = 0; i < 512; i++) begin
      a4 = 4'(i); b4 = 4'(i >> 4); cin4 = 1'(i >> 8);
      exp4 = {1'b0, a4} + {1'b0, b4} + {4'd0, cin4};
      start4 = 1'b1;
      tick();
      start4 = 1'b0;
      lat = -1; ndone = 0;
      for (int k = 0; k < 8; k++) begin
        if (done4 === 1'b1) begin
          ndone++;
          if (lat < 0) lat = k;
        end
        tick();
      end
      check_val("lat4", 32'(lat), 32'd4);
      check_val("ndone4", 32'(ndone), 32'd1);
      check_val("sum4", 32'({cout4, sum4}), 32'(exp4));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
